key_req_ctrl: RTL and testbench

KEY_REQ_CTRL -- requirements
Module: key_req_ctrl

---
 rtl/key_req_pkg.sv | 15 +
 rtl/key_req_timer.sv | 33 +++
 rtl/key_req_ctrl.sv | 128 ++++++++++++
 tb/tb_key_req_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/key_req_pkg.sv
// rtl/key_req_pkg.sv - shared types and defaults for the key request controller
package key_req_pkg;

  typedef logic [3:0] key_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 20;
  localparam int unsigned WAIT_W          = 5;

endpackage

// File: rtl/key_req_timer.sv
// rtl/key_req_timer.sv - saturating per-attempt wait counter with expiry compare
module key_req_timer
  import key_req_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              enable_i,
  output logic [WAIT_W-1:0] count_o,
  output logic              expired_o
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] count_q;

  // Holds at LAST so the count can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o   = count_q;
  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/key_req_ctrl.sv
// rtl/key_req_ctrl.sv - key request FSM; KEY_REQ_CTRL_RETRY_EN adds one retry attempt
module key_req_ctrl
  import key_req_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  key_t              cmd_key,
  output logic              req,
  output key_t              req_key,
  input  logic              ack,
  output logic              done_valid,
  input  logic              done_ready,
  output key_t              done_key,
  output logic [WAIT_W-1:0] done_wait,
  output logic              done_timeout
);

  state_t            state_q;
  logic              cmd_ready_q, req_q, done_valid_q, done_timeout_q;
  key_t              req_key_q, done_key_q;
  logic [WAIT_W-1:0] done_wait_q;

  logic [WAIT_W-1:0] wait_cnt;
  logic              expired, last_attempt, finish, retry_now, timer_clear, timer_en;

`ifdef KEY_REQ_CTRL_RETRY_EN
  logic retried_q;
  assign last_attempt = retried_q;
`else
  assign last_attempt = 1'b1;
`endif

  // Ack wins over a simultaneous expiry.
  always_comb begin
    finish      = 1'b0;
    retry_now   = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    if (state_q == REQ) begin
      finish    = ack || (expired && last_attempt);
      retry_now = !ack && expired && !last_attempt;
      timer_en  = !ack;
    end
    timer_clear = ((state_q == IDLE) && cmd_valid) || retry_now;
  end

  key_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .count_o   (wait_cnt),
    .expired_o (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cmd_ready_q    <= 1'b1;
      req_q          <= 1'b0;
      req_key_q      <= '0;
      done_valid_q   <= 1'b0;
      done_key_q     <= '0;
      done_wait_q    <= '0;
      done_timeout_q <= 1'b0;
`ifdef KEY_REQ_CTRL_RETRY_EN
      retried_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q     <= REQ;
            cmd_ready_q <= 1'b0;
            req_q       <= 1'b1;
            req_key_q   <= cmd_key;
`ifdef KEY_REQ_CTRL_RETRY_EN
            retried_q   <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (finish) begin
            state_q        <= RESP;
            req_q          <= 1'b0;
            req_key_q      <= '0;
            done_valid_q   <= 1'b1;
            done_key_q     <= req_key_q;
            done_wait_q    <= wait_cnt;
            done_timeout_q <= !ack;
          end
`ifdef KEY_REQ_CTRL_RETRY_EN
          if (retry_now) begin
            retried_q <= 1'b1;
          end
`endif
        end
        RESP: begin
          if (done_ready) begin
            state_q      <= IDLE;
            done_valid_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          cmd_ready_q  <= 1'b1;
          req_q        <= 1'b0;
          req_key_q    <= '0;
          done_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign req          = req_q;
  assign req_key      = req_key_q;
  assign done_valid   = done_valid_q;
  assign done_key     = done_key_q;
  assign done_wait    = done_wait_q;
  assign done_timeout = done_timeout_q;

endmodule

// File: tb/tb_key_req_ctrl.sv
// tb/tb_key_req_ctrl.sv - directed and randomized checks of key_req_ctrl against a reference model
module tb_key_req_ctrl;

  localparam int T = 20;
`ifdef KEY_REQ_CTRL_RETRY_EN
  localparam int ATTEMPTS = 2;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk, rst;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_key, req_key, done_key;
  logic       req, ack;
  logic       done_valid, done_ready, done_timeout;
  logic [4:0] done_wait;

  int tests = 0;
  int fails = 0;

  key_req_ctrl #(.TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_key      (cmd_key),
    .req          (req),
    .req_key      (req_key),
    .ack          (ack),
    .done_valid   (done_valid),
    .done_ready   (done_ready),
    .done_key     (done_key),
    .done_wait    (done_wait),
    .done_timeout (done_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First ack at REQ cycle ack_at (-1 = never). Each attempt spans T cycles.
  function automatic void model(input int ack_at, output int cycles, output int exp_wait,
                                output logic exp_to);
    int total;
    total = ATTEMPTS * T;
    if (ack_at >= 0 && ack_at < total) begin
      cycles   = ack_at + 1;
      exp_wait = ack_at % T;
      exp_to   = 1'b0;
    end else begin
      cycles   = total;
      exp_wait = T - 1;
      exp_to   = 1'b1;
    end
  endfunction

  task automatic run_cmd(input string tag, input logic [3:0] key, input int ack_at,
                         input int hold);
    int   n, cycles, exp_wait;
    logic exp_to;
    model(ack_at, cycles, exp_wait, exp_to);
    chk({tag, ".idle_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_key   = key;
    step();
    cmd_valid = 1'b0;
    cmd_key   = $urandom;
    chk({tag, ".req_key"}, req_key, key);
    n = 0;
    while (req === 1'b1 && n < 200) begin
      ack = (n == ack_at);
      step();
      n++;
    end
    ack = 1'b0;
    chk({tag, ".req_cycles"}, n, cycles);
    chk({tag, ".done_valid"}, done_valid, 1);
    chk({tag, ".done_key"}, done_key, key);
    chk({tag, ".done_wait"}, done_wait, exp_wait);
    chk({tag, ".done_timeout"}, done_timeout, exp_to);
    for (int h = 0; h < hold; h++) begin
      ack = 1'b1;
      step();
      ack = 1'b0;
      step();
      chk({tag, ".hold_rec"}, {done_valid, done_key, done_wait, done_timeout},
          {1'b1, key, 5'(exp_wait), exp_to});
      chk({tag, ".hold_busy"}, {cmd_ready, req}, 2'b00);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk({tag, ".release"}, {done_valid, cmd_ready, req}, 3'b010);
  endtask

  initial begin
    int   accepts, last_acc;
    logic [3:0] keyq[$];
    logic [3:0] k;
    rst = 1'b1; cmd_valid = 1'b0; cmd_key = '0; ack = 1'b0; done_ready = 1'b0;
    step();
    step();
    chk("reset.outs", {cmd_ready, req, req_key, done_valid, done_key, done_wait, done_timeout},
        {1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 5'd0, 1'b0});
    rst = 1'b0;

    // Stray ack / done_ready in IDLE must be ignored.
    ack = 1'b1; done_ready = 1'b1;
    step();
    step();
    chk("idle.noise", {cmd_ready, req, done_valid}, 3'b100);
    ack = 1'b0; done_ready = 1'b0;

    run_cmd("ack_third", 4'hA, 2, 0);
    run_cmd("timeout", 4'h3, -1, 0);
    run_cmd("ack_last", 4'h5, T - 1, 0);
    run_cmd("resp_hold", 4'hC, 4, 5);
    run_cmd("first_cycle", 4'h1, 0, 0);

    for (int i = 0; i < 10; i++) begin
      int a;
      a = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, ATTEMPTS * T + 2));
      run_cmd("random", 4'($urandom), a, int'($urandom_range(0, 2)));
    end

    // Reset while waiting at wait_cnt = 7.
    cmd_valid = 1'b1; cmd_key = 4'h9;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("rst_mid.req_before", req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid.after", {req, cmd_ready, done_valid}, 3'b010);
    for (int i = 0; i < 25; i++) step();
    chk("rst_mid.no_record", {done_valid, cmd_ready}, 2'b01);

    // Back-to-back commands with immediate ack and consumer always ready.
    cmd_valid = 1'b1; ack = 1'b1; done_ready = 1'b1;
    accepts = 0; last_acc = -3;
    for (int c = 0; c < 30; c++) begin
      k = 4'($urandom);
      cmd_key = k;
      if (cmd_ready === 1'b1) begin
        chk("b2b.spacing", c - last_acc, 3);
        last_acc = c;
        accepts++;
        keyq.push_back(k);
      end
      step();
      if (done_valid === 1'b1) begin
        chk("b2b.rec", {done_key, done_wait, done_timeout},
            {(keyq.size() > 0) ? keyq.pop_front() : 4'hx, 5'd0, 1'b0});
      end
    end
    chk("b2b.accepts", accepts, 10);
    cmd_valid = 1'b0; ack = 1'b0; done_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
